// File: rtl/lcd_digit_writer.sv
// lcd_digit_writer
//
// Drives four BCD digits from the timer stages onto an HD44780-compatible
// character LCD. The LCD uses an 8-bit parallel bus and is write-only, so
// RW is tied low.
//
// After reset the block waits out the LCD power-up time. It then sends the
// four init commands. From then on it rewrites the digit field whenever the
// digits change or an update strobe arrives.
//
// Ports
//   clk       system clock
//   rst       synchronous, active-low reset
//   digits    {d3,d2,d1,d0} BCD, d3 leftmost on the display
//   update    1-cycle strobe requesting a refresh of the digit field
//   lcd_data  LCD DB7..DB0
//   lcd_rs    0 = command, 1 = data
//   lcd_rw    constant 0
//   lcd_en    LCD enable strobe
//   busy      high during power-up, init and refresh
//   ready     high once init has completed (sticky until reset)
module lcd_digit_writer #(
    parameter int unsigned PWRUP_WAIT_CYC = 750000,
    parameter int unsigned EN_PULSE_CYC   = 12,
    parameter int unsigned CMD_WAIT_CYC   = 2000,
    parameter int unsigned CLR_WAIT_CYC   = 82000,
    parameter int unsigned START_COL      = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits,
    input  logic        update,
    output logic [7:0]  lcd_data,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en,
    output logic        busy,
    output logic        ready
);

    // One shared counter serves every wait, so size it for the largest one.
    localparam int unsigned MaxAB  = (PWRUP_WAIT_CYC > EN_PULSE_CYC) ? PWRUP_WAIT_CYC
                                                                      : EN_PULSE_CYC;
    localparam int unsigned MaxCD  = (CMD_WAIT_CYC > CLR_WAIT_CYC) ? CMD_WAIT_CYC : CLR_WAIT_CYC;
    localparam int unsigned CntMax = (MaxAB > MaxCD) ? MaxAB : MaxCD;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [7:0] CmdFunc  = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] CmdDisp  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] CmdEntry = 8'h06;  // increment, no shift
    localparam logic [7:0] CmdClear = 8'h01;  // clear, needs the long wait
    localparam logic [7:0] CmdPos   = 8'h80 | 8'(START_COL);

    localparam logic [CntW-1:0] PwrupLast = CntW'(PWRUP_WAIT_CYC - 1);
    localparam logic [CntW-1:0] EnLast    = CntW'(EN_PULSE_CYC - 1);
    localparam logic [CntW-1:0] CmdLast   = CntW'(CMD_WAIT_CYC - 1);
    localparam logic [CntW-1:0] ClrLast   = CntW'(CLR_WAIT_CYC - 1);

    typedef enum logic [1:0] {
        StPwrup,
        StInit,
        StIdle,
        StRefresh
    } state_e;

    // Sub-phases of one byte write: setup (data valid, en low), enable pulse,
    // then the post-strobe wait.
    typedef enum logic [1:0] {
        PhSetup,
        PhPulse,
        PhWait
    } phase_e;

    state_e            state_q, state_d;
    phase_e            phase_q, phase_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        data_q, data_d;
    logic              rs_q, rs_d;
    logic [15:0]       shadow_q, shadow_d;
    logic              pending_q, pending_d;
    logic              ready_q, ready_d;

    logic [CntW-1:0]   wait_last;
    logic              in_byte;
    logic              start_refresh;

    // Non-BCD digits are shown as '-'.
    function automatic logic [7:0] to_ascii(input logic [3:0] d);
        if (d <= 4'd9) begin
            return 8'h30 + {4'h0, d};
        end
        return 8'h2D;
    endfunction

    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0:    return CmdFunc;
            3'd1:    return CmdDisp;
            3'd2:    return CmdEntry;
            default: return CmdClear;
        endcase
    endfunction

    // Byte 0 positions the cursor; bytes 1..4 are d3..d0.
    function automatic logic [7:0] refresh_byte(input logic [2:0] idx, input logic [15:0] dg);
        case (idx)
            3'd0:    return CmdPos;
            3'd1:    return to_ascii(dg[15:12]);
            3'd2:    return to_ascii(dg[11:8]);
            3'd3:    return to_ascii(dg[7:4]);
            default: return to_ascii(dg[3:0]);
        endcase
    endfunction

    assign in_byte = (state_q == StInit) || (state_q == StRefresh);

    // Only the clear command needs the long settle time.
    assign wait_last = (!rs_q && (data_q == CmdClear)) ? ClrLast : CmdLast;

    assign start_refresh = update || pending_q || (digits != shadow_q);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        data_d    = data_q;
        rs_d      = rs_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        ready_d   = ready_q;

        // A strobe that arrives while busy is remembered, never dropped.
        if (update && (state_q != StIdle)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            StPwrup: begin
                if (cnt_q == PwrupLast) begin
                    state_d = StInit;
                    phase_d = PhSetup;
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    data_d  = init_cmd(3'd0);
                    rs_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StInit, StRefresh: begin
                case (phase_q)
                    PhSetup: begin
                        phase_d = PhPulse;
                        cnt_d   = '0;
                    end
                    PhPulse: begin
                        if (cnt_q == EnLast) begin
                            phase_d = PhWait;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                    PhWait: begin
                        if (cnt_q == wait_last) begin
                            cnt_d = '0;
                            if (state_q == StInit) begin
                                if (idx_q == 3'd3) begin
                                    ready_d = 1'b1;
                                    state_d = StIdle;
                                end else begin
                                    idx_d   = idx_q + 3'd1;
                                    data_d  = init_cmd(idx_q + 3'd1);
                                    phase_d = PhSetup;
                                end
                            end else begin
                                if (idx_q == 3'd4) begin
                                    state_d = StIdle;
                                end else begin
                                    // Data comes from the shadow so the field is
                                    // internally consistent even if digits move.
                                    idx_d   = idx_q + 3'd1;
                                    data_d  = refresh_byte(idx_q + 3'd1, shadow_q);
                                    rs_d    = 1'b1;
                                    phase_d = PhSetup;
                                end
                            end
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                    default: begin
                        phase_d = PhSetup;
                        cnt_d   = '0;
                    end
                endcase
            end

            StIdle: begin
                if (start_refresh) begin
                    shadow_d  = digits;
                    pending_d = 1'b0;
                    state_d   = StRefresh;
                    phase_d   = PhSetup;
                    cnt_d     = '0;
                    idx_d     = 3'd0;
                    data_d    = refresh_byte(3'd0, digits);
                    rs_d      = 1'b0;
                end
            end

            default: begin
                state_d = StPwrup;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StPwrup;
            phase_q   <= PhSetup;
            cnt_q     <= '0;
            idx_q     <= 3'd0;
            data_q    <= 8'h00;
            rs_q      <= 1'b0;
            shadow_q  <= 16'hFFFF;  // never equals valid BCD: forces first refresh
            pending_q <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            rs_q      <= rs_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            ready_q   <= ready_d;
        end
    end

    assign lcd_data = data_q;
    assign lcd_rs   = rs_q;
    assign lcd_rw   = 1'b0;
    assign lcd_en   = in_byte && (phase_q == PhPulse);
    assign busy     = (state_q != StIdle);
    assign ready    = ready_q;

endmodule

// File: tb/tb_lcd_digit_writer.sv
// tb_lcd_digit_writer
//
// Bench for lcd_digit_writer, built with short timing parameters.
//
// A bus monitor turns every lcd_en pulse into a captured byte record. The
// main sequence compares those records against the expected byte streams,
// which come either from a vector table or from a digit-to-ASCII model.
module tb_lcd_digit_writer;

    localparam int unsigned PW  = 20;
    localparam int unsigned EN  = 2;
    localparam int unsigned CMD = 5;
    localparam int unsigned CLR = 10;
    localparam int unsigned COL = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] digits = 16'h0500;
    logic        update = 1'b0;
    logic [7:0]  lcd_data;
    logic        lcd_rs;
    logic        lcd_rw;
    logic        lcd_en;
    logic        busy;
    logic        ready;

    lcd_digit_writer #(
        .PWRUP_WAIT_CYC(PW),
        .EN_PULSE_CYC  (EN),
        .CMD_WAIT_CYC  (CMD),
        .CLR_WAIT_CYC  (CLR),
        .START_COL     (COL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .digits  (digits),
        .update  (update),
        .lcd_data(lcd_data),
        .lcd_rs  (lcd_rs),
        .lcd_rw  (lcd_rw),
        .lcd_en  (lcd_en),
        .busy    (busy),
        .ready   (ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- bus monitor ----------------
    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         len;
        int         rise;
        logic       rdy;
    } cap_t;

    cap_t       cap_q[$];
    cap_t       cur;
    logic       prev_en   = 1'b0;
    logic       prev_rs   = 1'b0;
    logic [7:0] prev_data = 8'h00;

    initial begin
        forever begin
            @(negedge clk);
            if (lcd_en && !prev_en) begin
                cur.rs   = lcd_rs;
                cur.data = lcd_data;
                cur.len  = 1;
                cur.rise = cyc;
                cur.rdy  = ready;
                chk("setup_stable", {23'd0, prev_rs, prev_data}, {23'd0, lcd_rs, lcd_data});
                chk("rw_low", {31'd0, lcd_rw}, 32'd0);
            end else if (lcd_en && prev_en) begin
                cur.len++;
                chk("pulse_stable", {23'd0, lcd_rs, lcd_data}, {23'd0, prev_rs, prev_data});
            end else if (!lcd_en && prev_en) begin
                cap_q.push_back(cur);
            end
            prev_en   = lcd_en;
            prev_rs   = lcd_rs;
            prev_data = lcd_data;
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] ascii(input logic [3:0] d);
        if (d < 4'd10) return 8'h30 + 8'(d);
        return 8'h2D;
    endfunction

    // Element [4] is the first byte on the bus; each entry is {rs, data}.
    function automatic logic [4:0][8:0] model_refresh(input logic [15:0] dg);
        logic [4:0][8:0] r;
        r[4] = {1'b0, 8'h80 + 8'(COL)};
        for (int k = 0; k < 4; k++) begin
            r[3-k] = {1'b1, ascii(dg[15-4*k -: 4])};
        end
        return r;
    endfunction

    // Pops n captured bytes. Item i is compared with exp[n-1-i]. Within a
    // burst, the spacing between enable rises must be setup + pulse + wait.
    task automatic check_burst(input string name, input int n, input logic [4:0][8:0] exp,
                               input logic exp_rdy, input int first_rise);
        int   budget;
        int   prev_rise;
        int   prev_w;
        cap_t c;
        budget    = 0;
        prev_rise = 0;
        prev_w    = 0;
        while (cap_q.size() < n && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        if (cap_q.size() < n) begin
            chk({name, "_byte_count_timeout"}, cap_q.size(), n);
            return;
        end
        for (int i = 0; i < n; i++) begin
            c = cap_q.pop_front();
            chk($sformatf("%s_b%0d_rs_data", name, i), {23'd0, c.rs, c.data},
                {23'd0, exp[n-1-i]});
            chk($sformatf("%s_b%0d_en_len", name, i), c.len, EN);
            chk($sformatf("%s_b%0d_ready", name, i), {31'd0, c.rdy}, {31'd0, exp_rdy});
            if (i == 0 && first_rise >= 0) begin
                chk({name, "_first_rise"}, c.rise, first_rise);
            end
            if (i > 0) begin
                chk($sformatf("%s_b%0d_spacing", name, i), c.rise - prev_rise, 1 + EN + prev_w);
            end
            prev_rise = c.rise;
            prev_w    = (exp[n-1-i] == 9'h001) ? CLR : CMD;
        end
    endtask

    task automatic wait_idle(input string name);
        int budget;
        budget = 0;
        while (busy !== 1'b0 && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        chk({name, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        repeat (cycles) @(negedge clk);
        chk({name, "_no_bytes"}, cap_q.size(), 0);
        chk({name, "_not_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic pulse_update();
        @(negedge clk);
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
    endtask

    typedef struct {
        logic [15:0] dg;
        logic [39:0] bytes;  // first bus byte in the top octet
    } vec_t;

    vec_t            tbl[6];
    logic [4:0][8:0] init_exp;
    logic [4:0][8:0] e;
    int              t0;
    int              budget;
    int              mode;
    logic [15:0]     nd;
    logic            expect_ref;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        tbl[0] = '{16'h0459, 40'h86_30_34_35_39};
        tbl[1] = '{16'h0A0F, 40'h86_30_2D_30_2D};
        tbl[2] = '{16'h9999, 40'h86_39_39_39_39};
        tbl[3] = '{16'h1234, 40'h86_31_32_33_34};
        tbl[4] = '{16'hFB07, 40'h86_2D_2D_30_37};
        tbl[5] = '{16'h0500, 40'h86_30_35_30_30};
        init_exp = {9'h038, 9'h00C, 9'h006, 9'h001};

        // 1: reset values, power-up wait, init sequence
        rst    = 1'b0;
        digits = 16'h0500;
        repeat (3) @(negedge clk);
        chk("rst_lcd_data", {24'd0, lcd_data}, 32'h00);
        chk("rst_lcd_rs", {31'd0, lcd_rs}, 32'd0);
        chk("rst_lcd_rw", {31'd0, lcd_rw}, 32'd0);
        chk("rst_lcd_en", {31'd0, lcd_en}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        rst = 1'b1;
        t0  = cyc;
        check_burst("init", 4, init_exp, 1'b0, t0 + 1 + PW);

        // 2: automatic first refresh after init
        check_burst("auto_refresh", 5, model_refresh(16'h0500), 1'b1, -1);
        chk("ready_after_init", {31'd0, ready}, 32'd1);
        wait_idle("auto_refresh");

        // 3 and 5: table of digit changes
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            digits = tbl[i].dg;
            for (int k = 0; k < 5; k++) begin
                e[k] = {(k != 4), tbl[i].bytes[8*k +: 8]};
            end
            check_burst($sformatf("tbl%0d", i), 5, e, 1'b1, -1);
            wait_idle($sformatf("tbl%0d", i));
        end
        expect_quiet("unchanged", 60);

        // 4: three update strobes during a refresh collapse into one more refresh
        @(negedge clk);
        digits = 16'h2718;
        repeat (3) @(negedge clk);
        pulse_update();
        repeat (8) @(negedge clk);
        pulse_update();
        repeat (8) @(negedge clk);
        pulse_update();
        check_burst("upd_first", 5, model_refresh(16'h2718), 1'b1, -1);
        check_burst("upd_second", 5, model_refresh(16'h2718), 1'b1, -1);
        wait_idle("upd");
        expect_quiet("upd_once", 60);

        // Digit change mid-refresh: old value completes, new value follows
        @(negedge clk);
        digits = 16'h3141;
        repeat (5) @(negedge clk);
        digits = 16'h2653;
        check_burst("mid_old", 5, model_refresh(16'h3141), 1'b1, -1);
        check_burst("mid_new", 5, model_refresh(16'h2653), 1'b1, -1);
        wait_idle("mid");
        expect_quiet("mid_done", 50);

        // Randomised digit changes, update strobes and quiet periods
        for (int it = 0; it < 16; it++) begin
            mode = $urandom_range(0, 2);
            if (mode == 0) begin
                nd = 16'($urandom);
                @(negedge clk);
                expect_ref = (nd != digits);
                digits     = nd;
            end else if (mode == 1) begin
                pulse_update();
                expect_ref = 1'b1;
            end else begin
                expect_ref = 1'b0;
            end
            if (expect_ref) begin
                check_burst($sformatf("rnd%0d", it), 5, model_refresh(digits), 1'b1, -1);
                wait_idle($sformatf("rnd%0d", it));
            end else begin
                expect_quiet($sformatf("rnd%0d", it), 50);
            end
        end

        // 6: reset while lcd_en is high on a data byte
        @(negedge clk);
        digits = 16'h8642;
        budget = 0;
        while (!(lcd_en === 1'b1 && lcd_rs === 1'b1) && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        chk("data_pulse_seen", {31'd0, lcd_en & lcd_rs}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_en", {31'd0, lcd_en}, 32'd0);
        chk("midrst_ready", {31'd0, ready}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd1);
        chk("midrst_data", {24'd0, lcd_data}, 32'h00);
        @(negedge clk);
        rst = 1'b1;
        t0  = cyc;
        cap_q.delete();
        check_burst("reinit", 4, init_exp, 1'b0, t0 + 1 + PW);
        check_burst("reinit_refresh", 5, model_refresh(16'h8642), 1'b1, -1);
        wait_idle("reinit");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
